// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control/datapath bus between the multicycle MIPS controller and its datapath
//
// Purpose: groups the instruction fields, datapath flags and all datapath
// control strobes into one bundle.
// Ports (signals):
//   opcode, funct     IR[31:26], IR[5:0]            datapath -> controller
//   zero, mem_ready   ALU zero flag, memory done    datapath -> controller
//   pc_write .. pc_source  control strobes/selects  controller -> datapath
// Modports: master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory timeout and fault trap
//
// Purpose: sequences a shared ALU/memory/regfile datapath through
// FETCH, DECODE, EXECUTE, MEM and WB steps; traps illegal opcodes and
// memory handshakes that exceed MEM_TIMEOUT cycles.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          control/datapath bundle (master side)
//   state        current state encoding (debug)
//   instr_done   pulse on the last cycle of each instruction
//   instr_count  retired-instruction counter, wraps
//   fault        sticky trap flag
//   fault_cause  00 none, 01 illegal opcode, 10 memory timeout
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_multicycle_ctrl_if.master bus,
  output logic [3:0]           state,
  output logic                 instr_done,
  output logic [CNT_W-1:0]     instr_count,
  output logic                 fault,
  output logic [1:0]           fault_cause
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BNE = 6'b000101;

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [31:0] wait_cnt;
  logic        mem_wait;
  logic        fault_set;
  logic [1:0]  fault_code;
  logic        done_c;

  logic       c_pc_write, c_i_or_d, c_mem_read, c_mem_write, c_ir_write;
  logic       c_reg_write, c_alu_src_a;
  logic [1:0] c_reg_dst, c_mem_to_reg, c_alu_src_b, c_alu_op, c_pc_source;

  always_comb begin
    state_d      = state_q;
    mem_wait     = 1'b0;
    fault_set    = 1'b0;
    fault_code   = 2'b00;
    c_pc_write   = 1'b0;
    c_i_or_d     = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_ir_write   = 1'b0;
    c_reg_write  = 1'b0;
    c_alu_src_a  = 1'b0;
    c_reg_dst    = 2'b00;
    c_mem_to_reg = 2'b00;
    c_alu_src_b  = 2'b00;
    c_alu_op     = 2'b00;
    c_pc_source  = 2'b00;

    case (state_q)
      S_FETCH: begin
        c_mem_read  = 1'b1;
        c_alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          c_ir_write = 1'b1;
          c_pc_write = 1'b1;
          state_d    = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        c_alu_src_b = 2'b11;
        casez (bus.opcode)
          6'b000000: state_d = (bus.funct == 6'b001000) ? S_JR : S_R_EXEC;
          6'b100011,
          6'b101011: state_d = S_MEM_ADDR;
          6'b000100,
          6'b000101: state_d = S_BRANCH;
          6'b001???: state_d = S_I_EXEC;
          6'b000010: state_d = S_JUMP;
          6'b000011: state_d = S_JAL;
          default: begin
            state_d    = S_FAULT;
            fault_set  = 1'b1;
            fault_code = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
        state_d     = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        c_mem_read = 1'b1;
        c_i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
        else               mem_wait = 1'b1;
      end
      S_MEM_WB: begin
        c_reg_write  = 1'b1;
        c_mem_to_reg = 2'b01;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        c_mem_write = 1'b1;
        c_i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else               mem_wait = 1'b1;
      end
      S_R_EXEC: begin
        c_alu_src_a = 1'b1;
        c_alu_op    = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        c_reg_write = 1'b1;
        c_reg_dst   = 2'b01;
        state_d     = S_FETCH;
      end
      S_I_EXEC: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
        c_alu_op    = 2'b11;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        c_reg_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        c_alu_src_a = 1'b1;
        c_alu_op    = 2'b01;
        c_pc_source = 2'b01;
        // bne inverts the sense of the compare.
        c_pc_write  = bus.zero ^ (op_q == OP_BNE);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        c_pc_write  = 1'b1;
        c_pc_source = 2'b10;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH; that is the link value.
        c_pc_write   = 1'b1;
        c_pc_source  = 2'b10;
        c_reg_write  = 1'b1;
        c_reg_dst    = 2'b10;
        c_mem_to_reg = 2'b10;
        state_d      = S_FETCH;
      end
      S_JR: begin
        c_pc_write  = 1'b1;
        c_pc_source = 2'b11;
        state_d     = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d    = S_FAULT;
        fault_set  = 1'b1;
        fault_code = 2'b01;
      end
    endcase

    // A ready in the final allowed cycle wins, since mem_wait is only set
    // when mem_ready is low.
    if (MEM_TIMEOUT != 0 && mem_wait && wait_cnt == 32'(MEM_TIMEOUT - 1)) begin
      state_d    = S_FAULT;
      fault_set  = 1'b1;
      fault_code = 2'b10;
    end
  end

  assign done_c = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_FAULT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      op_q        <= 6'd0;
      wait_cnt    <= 32'd0;
      instr_count <= '0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      state_q <= state_d;
      // Memory states only self-loop while waiting, so any change of state
      // is an entry into a fresh wait window.
      if (state_d != state_q) wait_cnt <= 32'd0;
      else if (mem_wait)      wait_cnt <= wait_cnt + 32'd1;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (done_c) instr_count <= instr_count + 1'b1;
      if (fault_set) begin
        fault       <= 1'b1;
        fault_cause <= fault_code;
      end
    end
  end

  assign state          = state_q;
  assign instr_done     = rst_n & done_c;
  assign bus.pc_write   = rst_n & c_pc_write;
  assign bus.i_or_d     = rst_n & c_i_or_d;
  assign bus.mem_read   = rst_n & c_mem_read;
  assign bus.mem_write  = rst_n & c_mem_write;
  assign bus.ir_write   = rst_n & c_ir_write;
  assign bus.reg_write  = rst_n & c_reg_write;
  assign bus.alu_src_a  = rst_n & c_alu_src_a;
  assign bus.reg_dst    = rst_n ? c_reg_dst    : 2'b00;
  assign bus.mem_to_reg = rst_n ? c_mem_to_reg : 2'b00;
  assign bus.alu_src_b  = rst_n ? c_alu_src_b  : 2'b00;
  assign bus.alu_op     = rst_n ? c_alu_op     : 2'b00;
  assign bus.pc_source  = rst_n ? c_pc_source  : 2'b00;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       done;
    logic       pcw, iord, mrd, mwr, irw;
    logic [1:0] rdst, m2r;
    logic       rw, sa;
    logic [1:0] sb, aop, psrc;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  state;
  logic        instr_done;
  logic [31:0] instr_count;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .state       (state),
    .instr_done  (instr_done),
    .instr_count (instr_count),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  function automatic ctl_t mk(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.st   = state;
    c.done = instr_done;
    c.pcw  = bus.pc_write;
    c.iord = bus.i_or_d;
    c.mrd  = bus.mem_read;
    c.mwr  = bus.mem_write;
    c.irw  = bus.ir_write;
    c.rdst = bus.reg_dst;
    c.m2r  = bus.mem_to_reg;
    c.rw   = bus.reg_write;
    c.sa   = bus.alu_src_a;
    c.sb   = bus.alu_src_b;
    c.aop  = bus.alu_op;
    c.psrc = bus.pc_source;
    return c;
  endfunction

  task automatic chk_ctl(input string tag, input ctl_t e);
    ctl_t o;
    o = observe();
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Called just after a rising edge: drive, settle, check, advance one cycle.
  task automatic cyc(input string tag, input ctl_t e, input logic rdy, input logic z);
    bus.mem_ready = rdy;
    bus.zero      = z;
    #3;
    chk_ctl(tag, e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference sequence for one instruction, built from its class.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw);
    ctl_t e;
    bus.opcode = op;
    bus.funct  = fn;
    for (int i = 0; i <= fw; i++) begin
      e = mk(4'd0); e.mrd = 1'b1; e.sb = 2'b01;
      if (i == fw) begin e.irw = 1'b1; e.pcw = 1'b1; end
      cyc({tag, "/fetch"}, e, i == fw, rbit());
    end
    e = mk(4'd1); e.sb = 2'b11;
    cyc({tag, "/decode"}, e, rbit(), rbit());
    if (op == 6'd0 && fn == 6'b001000) begin
      e = mk(4'd13); e.pcw = 1'b1; e.psrc = 2'b11; e.done = 1'b1;
      cyc({tag, "/jr"}, e, rbit(), rbit());
    end else if (op == 6'd0) begin
      e = mk(4'd6); e.sa = 1'b1; e.aop = 2'b10;
      cyc({tag, "/rexec"}, e, rbit(), rbit());
      e = mk(4'd7); e.rw = 1'b1; e.rdst = 2'b01; e.done = 1'b1;
      cyc({tag, "/rwb"}, e, rbit(), rbit());
    end else if (op == 6'd35 || op == 6'd43) begin
      e = mk(4'd2); e.sa = 1'b1; e.sb = 2'b10;
      cyc({tag, "/maddr"}, e, rbit(), rbit());
      for (int i = 0; i <= mw; i++) begin
        if (op == 6'd35) begin e = mk(4'd3); e.mrd = 1'b1; end
        else begin e = mk(4'd5); e.mwr = 1'b1; e.done = (i == mw); end
        e.iord = 1'b1;
        cyc({tag, "/mem"}, e, i == mw, rbit());
      end
      if (op == 6'd35) begin
        e = mk(4'd4); e.rw = 1'b1; e.m2r = 2'b01; e.done = 1'b1;
        cyc({tag, "/mwb"}, e, rbit(), rbit());
      end
    end else if (op == 6'd4 || op == 6'd5) begin
      e = mk(4'd10); e.sa = 1'b1; e.aop = 2'b01; e.psrc = 2'b01; e.done = 1'b1;
      e.pcw = (op == 6'd4) ? z : !z;
      cyc({tag, "/branch"}, e, rbit(), z);
    end else if (op >= 6'd8 && op <= 6'd15) begin
      e = mk(4'd8); e.sa = 1'b1; e.sb = 2'b10; e.aop = 2'b11;
      cyc({tag, "/iexec"}, e, rbit(), rbit());
      e = mk(4'd9); e.rw = 1'b1; e.done = 1'b1;
      cyc({tag, "/iwb"}, e, rbit(), rbit());
    end else if (op == 6'd2) begin
      e = mk(4'd11); e.pcw = 1'b1; e.psrc = 2'b10; e.done = 1'b1;
      cyc({tag, "/j"}, e, rbit(), rbit());
    end else begin
      e = mk(4'd12); e.pcw = 1'b1; e.psrc = 2'b10; e.rw = 1'b1;
      e.rdst = 2'b10; e.m2r = 2'b10; e.done = 1'b1;
      cyc({tag, "/jal"}, e, rbit(), rbit());
    end
    exp_count++;
    chk_val({tag, "/count"}, instr_count, 32'(exp_count));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  initial begin
    logic [5:0] ops [16];
    logic [5:0] op, fn;
    ctl_t e;
    ops = '{6'd0, 6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8,
            6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd2, 6'd3};
    rst_n = 1'b0;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    // Held in reset: all controls low even with mem_ready high.
    #3;
    chk_ctl("reset_outputs", mk(4'd0));
    chk_val("reset_count", instr_count, 32'd0);
    chk_val("reset_fault", {30'd0, fault_cause}, {31'd0, fault} & 32'd0);
    chk_val("reset_fault_flag", {31'd0, fault}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr("add",  6'd0, 6'b100000, 1'b0, 0, 0);
    run_instr("lw3",  6'd35, 6'd0, 1'b0, 0, 3);
    run_instr("beq1", 6'd4, 6'd0, 1'b1, 0, 0);
    run_instr("beq0", 6'd4, 6'd0, 1'b0, 0, 0);
    run_instr("bne0", 6'd5, 6'd0, 1'b0, 0, 0);
    run_instr("bne1", 6'd5, 6'd0, 1'b1, 1, 0);
    run_instr("jal",  6'd3, 6'd0, 1'b0, 0, 0);
    run_instr("jr",   6'd0, 6'b001000, 1'b0, 0, 0);
    run_instr("sw2",  6'd43, 6'd0, 1'b0, 2, 2);

    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 15)];
      fn = 6'($urandom_range(0, 63));
      if (op == 6'd0 && rbit()) fn = 6'b001000;
      run_instr("rand", op, fn, rbit(), $urandom_range(0, 5), $urandom_range(0, 5));
    end
    chk_val("no_fault_after_rand", {30'd0, fault_cause}, 32'd0);

    // Ready on the 16th FETCH cycle still proceeds.
    run_instr("fetch16", 6'd2, 6'd0, 1'b0, 15, 0);
    chk_val("fetch16_fault", {31'd0, fault}, 32'd0);

    // Illegal opcode traps and holds.
    bus.opcode = 6'b111111; bus.funct = 6'd0;
    e = mk(4'd0); e.mrd = 1'b1; e.sb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
    cyc("ill/fetch", e, 1'b1, 1'b0);
    e = mk(4'd1); e.sb = 2'b11;
    cyc("ill/decode", e, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("ill/hold", mk(4'd15), rbit(), rbit());
    chk_val("ill_fault", {31'd0, fault}, 32'd1);
    chk_val("ill_cause", {30'd0, fault_cause}, 32'd1);
    chk_val("ill_count", instr_count, 32'(exp_count));

    do_reset();
    chk_val("rst_count", instr_count, 32'd0);
    chk_val("rst_fault", {31'd0, fault}, 32'd0);
    chk_val("rst_cause", {30'd0, fault_cause}, 32'd0);
    run_instr("post_rst_ori", 6'd13, 6'd0, 1'b0, 0, 0);

    // FETCH timeout: 16 cycles without ready.
    e = mk(4'd0); e.mrd = 1'b1; e.sb = 2'b01;
    for (int i = 0; i < 16; i++) cyc("to/fetch", e, 1'b0, 1'b0);
    #3;
    chk_ctl("to/fault_state", mk(4'd15));
    chk_val("to_cause", {30'd0, fault_cause}, 32'd2);
    chk_val("to_fault", {31'd0, fault}, 32'd1);
    @(posedge clk); #1;

    // MEM_WR timeout after a good address phase.
    do_reset();
    bus.opcode = 6'd43; bus.funct = 6'd0;
    e = mk(4'd0); e.mrd = 1'b1; e.sb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
    cyc("swto/fetch", e, 1'b1, 1'b0);
    e = mk(4'd1); e.sb = 2'b11;
    cyc("swto/decode", e, 1'b0, 1'b0);
    e = mk(4'd2); e.sa = 1'b1; e.sb = 2'b10;
    cyc("swto/maddr", e, 1'b0, 1'b0);
    e = mk(4'd5); e.mwr = 1'b1; e.iord = 1'b1;
    for (int i = 0; i < 16; i++) cyc("swto/wr", e, 1'b0, 1'b0);
    #3;
    chk_ctl("swto/fault_state", mk(4'd15));
    chk_val("swto_cause", {30'd0, fault_cause}, 32'd2);
    chk_val("swto_count", instr_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
